// File: rtl/syn_cond_decay.sv
// Post-synaptic conductance generator: accumulates weighted spikes into a
// saturating conductance that decays exponentially, with a refractory window.
module syn_cond_decay #(
  parameter int               WIDTH        = 14,
  parameter int               DECAY_SHIFT  = 3,
  parameter int               DECAY_PERIOD = 4,
  parameter int               REFRACT      = 2,
  parameter logic [WIDTH-1:0] G_MAX        = 14'h3FFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_spike,
  input  logic [WIDTH-1:0] i_weight,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_cond_decay,
  output logic             o_active,
  output logic             o_spike_accepted,
  output logic             o_sat
);

  localparam int TW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int RW = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DECAY_PERIOD - 1);
  localparam logic [RW-1:0] REF_LOAD  = RW'(REFRACT);
  localparam logic [RW-1:0] REF_EXIT  = RW'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECAY,
    S_REFRACT
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_tick_cnt;
  logic [RW-1:0]    r_ref_cnt;

  state_t           w_state_next;
  logic [TW-1:0]    w_tick_next;
  logic [RW-1:0]    w_ref_next;
  logic             w_tick;
  logic             w_accept;
  logic             w_over;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_g_dec;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_g_next;
  logic             w_active_next;

  // Datapath: decay is applied first, then any accepted weight is added on top.
  always_comb begin
    w_step   = o_cond_decay >> DECAY_SHIFT;
    w_tick   = (r_state != S_IDLE) && (r_tick_cnt == TICK_LAST);
    w_g_dec  = o_cond_decay;
    if (w_tick) begin
      if ((w_step == '0) && (o_cond_decay != '0))
        w_g_dec = o_cond_decay - WIDTH'(1);
      else
        w_g_dec = o_cond_decay - w_step;
    end
    w_accept = i_spike && (r_state != S_REFRACT);
    w_sum    = {1'b0, w_g_dec} + {1'b0, i_weight};
    w_over   = w_sum > {1'b0, G_MAX};
    w_g_next = w_g_dec;
    if (w_accept)
      w_g_next = w_over ? G_MAX : w_sum[WIDTH-1:0];
  end

  // The accepting cycle counts as the first refractory cycle, so the
  // REFRACT state is left once the counter would fall to 1.
  always_comb begin
    w_state_next = r_state;
    w_ref_next   = r_ref_cnt;
    if (w_accept) begin
      if (REFRACT >= 2) begin
        w_state_next = S_REFRACT;
        w_ref_next   = REF_LOAD;
      end else begin
        w_state_next = S_DECAY;
        w_ref_next   = '0;
      end
    end else begin
      case (r_state)
        S_DECAY: begin
          if (w_g_next == '0)
            w_state_next = S_IDLE;
        end
        S_REFRACT: begin
          if (r_ref_cnt <= REF_EXIT) begin
            w_ref_next   = '0;
            w_state_next = (w_g_next == '0) ? S_IDLE : S_DECAY;
          end else begin
            w_ref_next = r_ref_cnt - RW'(1);
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end

    if ((r_state == S_IDLE) || (w_state_next == S_IDLE))
      w_tick_next = '0;
    else if (w_tick)
      w_tick_next = '0;
    else
      w_tick_next = r_tick_cnt + TW'(1);

    w_active_next = (w_g_next != '0) || (w_state_next != S_IDLE);
  end

  // Single state register; clear wins over every same-cycle event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_tick_cnt       <= '0;
      r_ref_cnt        <= '0;
      o_cond_decay     <= '0;
      o_active         <= 1'b0;
      o_spike_accepted <= 1'b0;
      o_sat            <= 1'b0;
    end else if (i_clear) begin
      r_state          <= S_IDLE;
      r_tick_cnt       <= '0;
      r_ref_cnt        <= '0;
      o_cond_decay     <= '0;
      o_active         <= 1'b0;
      o_spike_accepted <= 1'b0;
      o_sat            <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_tick_cnt       <= w_tick_next;
      r_ref_cnt        <= w_ref_next;
      o_cond_decay     <= w_g_next;
      o_active         <= w_active_next;
      o_spike_accepted <= w_accept;
      o_sat            <= w_accept && w_over;
    end
  end

endmodule

// File: tb/tb_syn_cond_decay.sv
// Directed self-checking bench for syn_cond_decay: hand-computed conductance
// values for accumulation, refractory rejection, saturation, decay and clear.
module tb_syn_cond_decay;

  logic        clk;
  logic        reset;
  logic        iSpike;
  logic [13:0] iWeight;
  logic        iClear;
  logic [13:0] oCond;
  logic        oActive;
  logic        oAccepted;
  logic        oSat;

  int checks   = 0;
  int failures = 0;

  syn_cond_decay dut (
    .clk              (clk),
    .reset            (reset),
    .i_spike          (iSpike),
    .i_weight         (iWeight),
    .i_clear          (iClear),
    .o_cond_decay     (oCond),
    .o_active         (oActive),
    .o_spike_accepted (oAccepted),
    .o_sat            (oSat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one spike for the coming rising edge, returns at the following falling edge.
  task automatic applyStimulus(input logic spike, input logic [13:0] w);
    iSpike  = spike;
    iWeight = w;
    @(negedge clk);
    iSpike  = 1'b0;
    iWeight = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pulseClear();
    iClear = 1'b1;
    @(negedge clk);
    iClear = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    iSpike  = 1'b0;
    iWeight = '0;
    iClear  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_cond", 32'(oCond), 32'h0);
    checkOutput("rst_active", 32'(oActive), 32'h0);
    checkOutput("rst_acc", 32'(oAccepted), 32'h0);
    checkOutput("rst_sat", 32'(oSat), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single spike decay");
    applyStimulus(1'b1, 14'h0800);
    checkOutput("t2_cond_n1", 32'(oCond), 32'h0800);
    checkOutput("t2_acc_n1", 32'(oAccepted), 32'h1);
    checkOutput("t2_active_n1", 32'(oActive), 32'h1);
    @(negedge clk);
    checkOutput("t2_acc_n2", 32'(oAccepted), 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("t2_cond_n4", 32'(oCond), 32'h0800);
    @(negedge clk);
    checkOutput("t2_cond_n5", 32'(oCond), 32'h0700);
    repeat (4) @(negedge clk);
    checkOutput("t2_cond_n9", 32'(oCond), 32'h0620);
    pulseClear();

    $display("[TB] async reset mid-decay");
    applyStimulus(1'b1, 14'h0800);
    repeat (4) @(negedge clk);
    checkOutput("t1_pre_cond", 32'(oCond), 32'h0700);
    reset = 1'b0;
    #1;
    checkOutput("t1_cond", 32'(oCond), 32'h0);
    checkOutput("t1_active", 32'(oActive), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t1_idle_active", 32'(oActive), 32'h0);
    checkOutput("t1_idle_cond", 32'(oCond), 32'h0);

    $display("[TB] refractory rejection");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 14'h0100);
      checkOutput($sformatf("t3_acc_%0d", i), 32'(oAccepted), (i % 2 == 0) ? 32'h1 : 32'h0);
      if (i >= 2)
        checkOutput($sformatf("t3_cond_%0d", i), 32'(oCond), 32'h0200);
    end
    @(negedge clk);
    checkOutput("t3_cond_n5", 32'(oCond), 32'h01C0);
    pulseClear();

    $display("[TB] saturation");
    applyStimulus(1'b1, 14'h3800);
    @(negedge clk);
    applyStimulus(1'b1, 14'h1000);
    checkOutput("t4_cond", 32'(oCond), 32'h3FFF);
    checkOutput("t4_sat", 32'(oSat), 32'h1);
    checkOutput("t4_acc", 32'(oAccepted), 32'h1);
    @(negedge clk);
    checkOutput("t4_sat_drop", 32'(oSat), 32'h0);
    checkOutput("t4_cond_hold", 32'(oCond), 32'h3FFF);
    pulseClear();

    $display("[TB] small value decays to zero");
    applyStimulus(1'b1, 14'h0005);
    checkOutput("t5_cond_n1", 32'(oCond), 32'h0005);
    repeat (4) @(negedge clk);
    checkOutput("t5_cond_n5", 32'(oCond), 32'h0004);
    repeat (15) @(negedge clk);
    checkOutput("t5_cond_n20", 32'(oCond), 32'h0001);
    checkOutput("t5_active_n20", 32'(oActive), 32'h1);
    @(negedge clk);
    checkOutput("t5_cond_n21", 32'(oCond), 32'h0);
    checkOutput("t5_active_n21", 32'(oActive), 32'h0);
    repeat (5) @(negedge clk);
    checkOutput("t5_cond_stay", 32'(oCond), 32'h0);

    $display("[TB] zero weight spike");
    applyStimulus(1'b1, 14'h0000);
    checkOutput("tw_acc", 32'(oAccepted), 32'h1);
    checkOutput("tw_cond", 32'(oCond), 32'h0);
    checkOutput("tw_active", 32'(oActive), 32'h1);
    @(negedge clk);
    checkOutput("tw_active_drop", 32'(oActive), 32'h0);

    $display("[TB] clear beats spike");
    applyStimulus(1'b1, 14'h0300);
    @(negedge clk);
    checkOutput("t6_pre_cond", 32'(oCond), 32'h0300);
    iClear  = 1'b1;
    iSpike  = 1'b1;
    iWeight = 14'h0400;
    @(negedge clk);
    iClear  = 1'b0;
    iSpike  = 1'b0;
    iWeight = '0;
    checkOutput("t6_cond", 32'(oCond), 32'h0);
    checkOutput("t6_acc", 32'(oAccepted), 32'h0);
    checkOutput("t6_active", 32'(oActive), 32'h0);
    applyStimulus(1'b1, 14'h0010);
    checkOutput("t6_after_cond", 32'(oCond), 32'h0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
